// File: rtl/mux4way16_rr_arbiter_pkg.sv
// Shared constants for the four-way round-robin word arbiter.
// Output-register states, requester indices and the word width.
package mux4way16_rr_arbiter_pkg;

    localparam int WORD_W = 16;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    // 2-bit arithmetic gives the 3 -> 0 wrap for free.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/Mux4Way16.sv
// Four-input word multiplexer used as the arbiter datapath.
// sel picks a, b, c or d onto out.
module Mux4Way16
    import mux4way16_rr_arbiter_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    input  logic [1:0]        sel,
    output logic [WORD_W-1:0] out
);

    always_comb begin
        out = a;
        case (sel)
            REQ_A:   out = a;
            REQ_B:   out = b;
            REQ_C:   out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Rotating first-one picker: scans req starting at index start and wrapping.
// Returns a one-hot grant, its index and whether anything was requesting.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic       found;
    logic [1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < 4; k++) begin
            pos = start + 2'(k);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/mux4way16_rr_arbiter.sv
// Four requesters share one registered 16-bit output; one winner per cycle in round-robin order.
// state | meaning
// EMPTY | output register free, out_valid=0
// FULL  | output register holds a word not yet accepted, out_valid=1
module mux4way16_rr_arbiter
    import mux4way16_rr_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    output logic [3:0]        gnt,
    output logic [WORD_W-1:0] out,
    output logic [1:0]        out_src,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [0:0]        state_q;
    logic [1:0]        ptr_q;
    logic [1:0]        start;
    logic [1:0]        win_idx;
    logic [3:0]        pick_gnt;
    logic              any_req;
    logic              can_load;
    logic              load;
    logic [WORD_W-1:0] mux_out;

    assign out_valid = (state_q == ST_FULL);
    assign can_load  = !out_valid || out_ready;
    assign start     = FIXED_PRIO ? REQ_A : next_idx(ptr_q);

    rr_pick4 u_pick (
        .req   (req),
        .start (start),
        .gnt   (pick_gnt),
        .idx   (win_idx),
        .any   (any_req)
    );

    Mux4Way16 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (win_idx),
        .out (mux_out)
    );

    // reset is folded in so gnt drops the moment reset rises, not at the next edge.
    assign load = can_load && any_req && !reset;
    assign gnt  = load ? pick_gnt : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out     <= '0;
            out_src <= '0;
            ptr_q   <= REQ_D;
        end else if (load) begin
            state_q <= ST_FULL;
            out     <= mux_out;
            out_src <= win_idx;
            ptr_q   <= win_idx;
        end else if (out_valid && out_ready) begin
            state_q <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux4way16_rr_arbiter.sv
// Scoreboard bench for the round-robin arbiter: a behavioural model predicts grants and queues
// expected words; a monitor pops and compares each word as the consumer accepts it.
module tb_mux4way16_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] a, b, c, d;
    logic [3:0]  gnt;
    logic [15:0] out;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    mux4way16_rr_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .out       (out),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] word;
        logic [1:0]  src;
    } item_t;

    item_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    int          m_ptr;
    bit          m_valid;
    logic [15:0] words[4];
    bit          pend[4];
    logic [3:0]  last_gnt;
    logic [15:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr   = 3;
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    endtask

    // One cycle: drive just after the rising edge, check gnt combinationally, advance the model.
    task automatic step(input logic [3:0] r, input logic rdy);
        int win;
        @(posedge clk);
        #2;
        req = r; out_ready = rdy;
        a = words[0]; b = words[1]; c = words[2]; d = words[3];
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        win = -1;
        if ((!m_valid || rdy) && r != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + 1 + k) % 4;
                if (win < 0 && r[j]) win = j;
            end
        end
        last_gnt = (win >= 0) ? 4'(1 << win) : 4'b0000;
        chk("gnt", {28'd0, gnt}, {28'd0, last_gnt});
        if (win >= 0) begin
            sb.push_back('{word: words[win], src: 2'(win)});
            m_ptr      = win;
            m_valid    = 1'b1;
            pend[win]  = 1'b0;
            words[win] = 16'($urandom);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        req = 4'b0000;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        item_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {14'd0, out_src, out}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out", {16'd0, out}, {16'd0, e.word});
                    chk("out_src", {30'd0, out_src}, {30'd0, e.src});
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] r;
        reset = 1'b1; req = '0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        model_reset();
        #12 reset = 1'b0;
        reset_pulse();

        words[2] = 16'hBEEF;
        step(4'b0100, 1'b1);
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        reset_pulse();
        words[0] = 16'h000A; words[1] = 16'h000B; words[2] = 16'h000C; words[3] = 16'h000D;
        for (int k = 0; k < 5; k++) begin
            words[0] = 16'h000A; words[1] = 16'h000B; words[2] = 16'h000C; words[3] = 16'h000D;
            step(4'b1111, 1'b1);
            chk("rr_order", {28'd0, gnt}, 32'(1 << (k % 4)));
        end
        step(4'b0000, 1'b1);

        step(4'b0100, 1'b0);
        held = out;
        step(4'b0011, 1'b0);
        held = out;
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 1'b0);
            chk("bp_gnt", {28'd0, gnt}, 32'd0);
            chk("bp_out", {16'd0, out}, {16'd0, held});
        end
        step(4'b0011, 1'b1);
        chk("bp_resume", {28'd0, gnt}, 32'h1);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);

        reset_pulse();
        step(4'b1010, 1'b1);
        chk("skip_b", {28'd0, gnt}, 32'h2);
        step(4'b1010, 1'b1);
        chk("wrap_d", {28'd0, gnt}, 32'h8);
        step(4'b0000, 1'b1);

        words[3] = 16'h1234;
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        chk("held_1234", {16'd0, out}, 32'h1234);
        reset_pulse();
        step(4'b1000, 1'b1);
        chk("post_rst_d", {28'd0, gnt}, 32'h8);
        step(4'b0000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) pend[i] = ($urandom_range(0, 1) == 1);
                else if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
            end
            r = {pend[3], pend[2], pend[1], pend[0]};
            step(r, ($urandom_range(0, 3) != 0));
        end

        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
